// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: takes a bitstream as a valid/ready word stream and feeds
// NUM_CHAINS parallel tile configuration shift chains, one bit per chain per shift.
// Define FABRIC_CFG_LOADER_CRC_EN to add the rotate-xor checksum and the trailer check.
module fabric_cfg_loader #(
    parameter int NUM_CHAINS = 4,
    parameter int WORD_W     = 32,
    parameter int CHAIN_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  cfg_shift,
    output logic [NUM_CHAINS-1:0] cfg_bit,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_error
);

    localparam int SHIFTS_PER_WORD = WORD_W / NUM_CHAINS;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BEAT_W = (SHIFTS_PER_WORD > 1) ? $clog2(SHIFTS_PER_WORD) : 1;
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(SHIFTS_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
`ifdef FABRIC_CFG_LOADER_CRC_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WORD_W-1:0]   sreg;
    logic [CNT_W-1:0]    shift_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
`ifdef FABRIC_CFG_LOADER_CRC_EN
    logic [WORD_W-1:0]   chk;
`endif

    // State register; everything the outside world sees is decoded from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; abort overrides every other transition.
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        cfg_shift = 1'b0;
        cfg_bit   = '0;
        busy      = 1'b0;
        cfg_done  = 1'b0;
        cfg_error = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) state_d = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                cfg_shift = 1'b1;
                cfg_bit   = sreg[NUM_CHAINS-1:0];
                if (beat_cnt == LAST_BEAT) begin
                    if (shift_cnt == LAST_SHIFT) begin
`ifdef FABRIC_CFG_LOADER_CRC_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
`ifdef FABRIC_CFG_LOADER_CRC_EN
            CHECK: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid) state_d = (s_data == chk) ? DONE : ERR;
            end
`endif
            DONE: begin
                cfg_done = 1'b1;
                if (start) state_d = LOAD;
            end
            ERR: begin
`ifdef FABRIC_CFG_LOADER_CRC_EN
                cfg_error = 1'b1;
`endif
                if (start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Word register, shift/beat counters and checksum; a dropped word never reaches sreg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            shift_cnt <= '0;
            beat_cnt  <= '0;
`ifdef FABRIC_CFG_LOADER_CRC_EN
            chk       <= '0;
`endif
        end else if (abort) begin
            sreg      <= '0;
            shift_cnt <= '0;
            beat_cnt  <= '0;
`ifdef FABRIC_CFG_LOADER_CRC_EN
            chk       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        sreg      <= '0;
                        shift_cnt <= '0;
                        beat_cnt  <= '0;
`ifdef FABRIC_CFG_LOADER_CRC_EN
                        chk       <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        sreg     <= s_data;
                        beat_cnt <= '0;
`ifdef FABRIC_CFG_LOADER_CRC_EN
                        chk      <= {chk[WORD_W-2:0], chk[WORD_W-1]} ^ s_data;
`endif
                    end
                end
                SHIFT: begin
                    sreg      <= sreg >> NUM_CHAINS;
                    shift_cnt <= shift_cnt + CNT_W'(1);
                    beat_cnt  <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// tb_fabric_cfg_loader: table vectors, randomized loads and hand-written corner
// sequences for fabric_cfg_loader with NUM_CHAINS=4, WORD_W=8, CHAIN_LEN=8.
module tb_fabric_cfg_loader;

    localparam int NC     = 4;
    localparam int W      = 8;
    localparam int CL     = 8;
    localparam int SPW    = W / NC;
    localparam int WPL    = CL * NC / W;
    localparam int NSHIFT = CL;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic          cfg_shift;
    logic [NC-1:0] cfg_bit;
    logic          busy;
    logic          cfg_done;
    logic          cfg_error;

    int checks;
    int failures;
    logic [NC-1:0] shift_log[$];

    typedef struct {
        logic [WPL*W-1:0] words;
        logic [W-1:0]     trailer;
        int               gap_idx;
        int               gap_len;
        bit               exp_done;
        bit               exp_err;
    } vec_t;

    vec_t vecs[4];

    fabric_cfg_loader #(
        .NUM_CHAINS(NC),
        .WORD_W(W),
        .CHAIN_LEN(CL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .cfg_shift(cfg_shift),
        .cfg_bit(cfg_bit),
        .busy(busy),
        .cfg_done(cfg_done),
        .cfg_error(cfg_error)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every chain bit group on the falling edge and make sure no shift happens while a word can be accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_shift) shift_log.push_back(cfg_bit);
            checks++;
            if (cfg_shift && s_ready) begin
                failures++;
                $display("[TB] FAIL shift_while_ready: cfg_shift=%0b s_ready=%0b required no overlap", cfg_shift, s_ready);
            end
        end
    end

    // Hard stop if something hangs despite the per-handshake bounds.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic vl, input logic [W-1:0] dt);
        start   = st;
        abort   = ab;
        s_valid = vl;
        s_data  = dt;
        step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Holds s_valid with the given word until the loader takes it; returns just after the accepting edge.
    task automatic sendWord(input logic [W-1:0] w, input string tag);
        bit got;
        got     = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 50 && !got; i++) begin
            if (s_ready) got = 1'b1;
            step();
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL %s.handshake: s_ready stayed %0b, required 1 within 50 cycles", tag, s_ready);
        end
    endtask

    // Reference checksum: rotate the running value left by one, then xor in each data word.
    function automatic logic [W-1:0] modelChk(input logic [WPL*W-1:0] words);
        int c;
        c = 0;
        for (int i = 0; i < WPL; i++) begin
            c = ((c << 1) | (c >> (W - 1))) & ((1 << W) - 1);
            c = c ^ int'(words[i*W +: W]);
        end
        return W'(c);
    endfunction

    // One complete load from DONE/ERR/IDLE, optionally stalling s_valid before word gap_idx.
    task automatic runLoad(input logic [WPL*W-1:0] words, input logic [W-1:0] trailer,
                           input int gap_idx, input int gap_len,
                           input bit exp_done, input bit exp_err, input string tag);
        int exp_bits[$];
        int sz;
        int n;
        for (int i = 0; i < WPL; i++)
            for (int k = 0; k < SPW; k++)
                exp_bits.push_back((int'(words[i*W +: W]) >> (k * NC)) & ((1 << NC) - 1));
        shift_log.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput({tag, ".ready_after_start"}, s_ready, 1);
        checkOutput({tag, ".flags_cleared"}, {cfg_done, cfg_error}, 0);
        for (int i = 0; i < WPL; i++) begin
            if (i == gap_idx && gap_len > 0) begin
                s_valid = 1'b0;
                repeat (SPW) step();
                sz = shift_log.size();
                repeat (gap_len) step();
                checkOutput({tag, ".gap_no_shift"}, shift_log.size(), sz);
            end
            sendWord(words[i*W +: W], tag);
        end
`ifdef FABRIC_CFG_LOADER_CRC_EN
        sendWord(trailer, {tag, ".trailer"});
        s_valid = 1'b0;
`else
        s_valid = 1'b0;
        repeat (SPW - 1) step();
        checkOutput({tag, ".done_not_early"}, cfg_done, 0);
        step();
`endif
        checkOutput({tag, ".cfg_done"}, cfg_done, exp_done);
        checkOutput({tag, ".cfg_error"}, cfg_error, exp_err);
        checkOutput({tag, ".busy_end"}, busy, 0);
        checkOutput({tag, ".shift_count"}, shift_log.size(), NSHIFT);
        n = (shift_log.size() < exp_bits.size()) ? shift_log.size() : exp_bits.size();
        for (int j = 0; j < n; j++)
            checkOutput($sformatf("%s.bit%0d", tag, j), shift_log[j], exp_bits[j]);
        $display("[TB] %s load finished (words %08h, trailer %02h)", tag, words, trailer);
    endtask

    function automatic logic [31:0] allOutputs();
        return {22'd0, s_ready, cfg_shift, cfg_bit, busy, cfg_done, cfg_error};
    endfunction

    initial begin
        logic [WPL*W-1:0] rw;
        logic [W-1:0]     rt;
        logic [W-1:0]     rc;
        bit               bad;
        bit               rdone;
        bit               rerr;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;

        // Fixed vectors; expected flags derived by hand from the checksum rule.
        vecs[0] = '{32'h08040201, 8'h00, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{32'h08040201, 8'h01, 0, 0, 1'b1, 1'b0};
        vecs[2] = '{32'h00FF3CA5, 8'h22, 2, 3, 1'b1, 1'b0};
        vecs[3] = '{32'hF00FC35A, 8'h33, 1, 1, 1'b1, 1'b0};
`ifdef FABRIC_CFG_LOADER_CRC_EN
        vecs[1].exp_done = 1'b0;
        vecs[1].exp_err  = 1'b1;
`endif

        // Reset and idle: nothing moves.
        step();
        step();
        checkOutput("reset_outputs", allOutputs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("idle_outputs%0d", i), allOutputs(), 0);
        end
        checkOutput("idle_no_shift", shift_log.size(), 0);

        // Single word 0xA5 with s_valid held: low nibble first, then the high one, then ready again.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("a5.load_ready", s_ready, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5);
        checkOutput("a5.shift0", cfg_shift, 1);
        checkOutput("a5.bit0", cfg_bit, 4'h5);
        checkOutput("a5.ready_low", s_ready, 0);
        step();
        checkOutput("a5.shift1", cfg_shift, 1);
        checkOutput("a5.bit1", cfg_bit, 4'hA);
        step();
        checkOutput("a5.ready_again", s_ready, 1);
        checkOutput("a5.shift_off", cfg_shift, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("a5.abort_idle", busy, 0);

        // Table-driven loads.
        for (int v = 0; v < 4; v++)
            runLoad(vecs[v].words, vecs[v].trailer, vecs[v].gap_idx, vecs[v].gap_len,
                    vecs[v].exp_done, vecs[v].exp_err, $sformatf("vec%0d", v));

        // Error (or done) flag from the previous load clears on the next start.
        runLoad(vecs[1].words, vecs[1].trailer, 0, 0, vecs[1].exp_done, vecs[1].exp_err, "vec1_again");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("restart.cfg_error", cfg_error, 0);
        checkOutput("restart.cfg_done", cfg_done, 0);
        checkOutput("restart.ready", s_ready, 1);
        checkOutput("restart.busy", busy, 1);

        // abort with a word offered in LOAD: back to IDLE and the word is dropped.
        sz_check: begin
            int sz0;
            sz0 = shift_log.size();
            applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
            s_valid = 1'b0;
            checkOutput("abort_hs.busy", busy, 0);
            checkOutput("abort_hs.ready", s_ready, 0);
            step();
            checkOutput("abort_hs.no_shift", shift_log.size(), sz0);
        end

        // start and abort together from IDLE: abort wins.
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("start_abort.busy", busy, 0);

        // abort during the second word's shifting.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        sendWord(8'h11, "abort_mid.w0");
        sendWord(8'h22, "abort_mid.w1");
        s_valid = 1'b0;
        checkOutput("abort_mid.shifting", cfg_shift, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("abort_mid.outputs", allOutputs(), 0);
        runLoad(vecs[0].words, vecs[0].trailer, 0, 0, vecs[0].exp_done, vecs[0].exp_err, "after_abort");

        // abort in DONE clears cfg_done.
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("abort_done.cfg_done", cfg_done, 0);

        // Reset in the middle of a load: outputs drop without waiting for a clock edge.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        sendWord(8'hA5, "reset_mid.w0");
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid.outputs", allOutputs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        runLoad(vecs[2].words, vecs[2].trailer, 0, 0, vecs[2].exp_done, vecs[2].exp_err, "after_reset");

        // Randomized loads checked against the reference model.
        for (int r = 0; r < 12; r++) begin
            rw  = $urandom;
            rc  = modelChk(rw);
            bad = ($urandom_range(0, 3) == 0);
            rt  = bad ? (rc ^ W'(1 << $urandom_range(0, W - 1))) : rc;
`ifdef FABRIC_CFG_LOADER_CRC_EN
            rerr  = bad;
            rdone = !bad;
`else
            rerr  = 1'b0;
            rdone = 1'b1;
`endif
            runLoad(rw, rt, $urandom_range(1, WPL - 1), $urandom_range(0, 4), rdone, rerr,
                    $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fabric_cfg_loader.md
# fabric_cfg_loader

Parametrised configuration loader for the tiled fabric: accepts a bitstream as a valid/ready word stream and drives NUM_CHAINS parallel tile configuration shift chains, one per tile column. It replaces per-tile hand wiring of configuration at the fabric top. Every CLB, SRAM and MAC tile column hangs off one chain output. It reports completion and, optionally, bitstream integrity.

## Interface
- NUM_CHAINS, 4: number of parallel config chains, one bit per chain per shift.
- WORD_W, 32: input word width; must be a multiple of NUM_CHAINS.
- CHAIN_LEN, 1024: shifts per load, equal to the bit length of each chain; CHAIN_LEN*NUM_CHAINS must be a multiple of WORD_W.
- clk  input  1  sole clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- abort  input  1  synchronous; returns to IDLE from any state.
- s_data  input  WORD_W  bitstream word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a word this cycle.
- cfg_shift  output  1  chains shift on this cycle.
- cfg_bit  output  NUM_CHAINS  bit i feeds chain i.
- busy  output  1  high in any state other than IDLE, DONE or ERR.
- cfg_done  output  1  load complete and valid.
- cfg_error  output  1  integrity check failed.

## Operation
- The design has one clock, clk. Reset rst_n is asynchronous and active-low.
- States: IDLE, LOAD, SHIFT, CHECK (CRC build only), DONE, ERR.
- IDLE/DONE/ERR, start=1: clear shift counter, checksum and flags; go to LOAD. start is ignored in LOAD, SHIFT and CHECK.
- LOAD: s_ready=1. On s_valid&&s_ready, latch s_data into word register sreg, update checksum, go to SHIFT.
- SHIFT: each cycle cfg_shift=1 and cfg_bit=sreg[NUM_CHAINS-1:0]; then sreg shifts right by NUM_CHAINS and the shift counter increments.
- SHIFT exit: after WORD_W/NUM_CHAINS cycles the word is exhausted.
  - Shift counter == CHAIN_LEN: go to CHECK if CRC is compiled in, else DONE.
  - Otherwise: go back to LOAD.
- Checksum (CRC build): chk is WORD_W bits, reset 0. Per accepted data word, chk <= rotl1(chk) ^ s_data.
- CHECK: s_ready=1; accepts one trailer word.
  - Trailer == chk: go to DONE.
  - Otherwise: go to ERR.
  - The trailer is not shifted out.
- DONE: cfg_done=1, held until the next start or abort.
- ERR: cfg_error=1, held until the next start or abort. cfg_done stays 0.
- abort: forces IDLE on the next edge and clears cfg_done, cfg_error and all counters. abort takes priority over start and over a word handshake in the same cycle; that word is dropped.

## Timing
- Reset values: state IDLE; s_ready, cfg_shift, busy, cfg_done, cfg_error all 0; cfg_bit 0; sreg, chk and counters 0.
- All outputs are registered or decoded from the state register only. There is no combinational path from s_valid to s_ready.
- Handshake: a word transfers on the edge where s_valid&&s_ready. s_valid may drop or stay low in LOAD indefinitely; the loader waits with cfg_shift=0.
- Per-word cost: 1 LOAD cycle (minimum) + WORD_W/NUM_CHAINS SHIFT cycles. cfg_shift is never high in LOAD.
- First cfg_shift is asserted the cycle after the accepting edge.
- cfg_done rises the cycle after the final shift (non-CRC build) or the cycle after the trailer handshake (CRC build).
- Reset asserted mid-load: immediate return to reset values. Tiles must be reloaded.

## Configuration
- Macro: FABRIC_CFG_LOADER_CRC_EN.
- Defined: checksum datapath and the CHECK state exist; the trailer word is required; cfg_error is functional.
- Undefined: no checksum register and no CHECK state; the load ends in DONE after the final shift; ERR is unreachable and cfg_error is tied 0.

## Test plan
All scenarios use NUM_CHAINS=4, WORD_W=8, CHAIN_LEN=8 (4 data words, 2 shifts per word).
- Reset, then idle 5 cycles: all outputs 0, state IDLE, cfg_shift never asserted.
- start, then word 0xA5 with s_valid held: cfg_bit=0x5 then 0xA on two consecutive cfg_shift cycles, followed by s_ready=1 again.
- Full load of 0x01,0x02,0x04,0x08, trailer 0x00 (CRC build): exactly 8 cfg_shift pulses; cfg_done=1 and cfg_error=0 one cycle after the trailer is accepted.
- Same load with trailer 0x01: cfg_error=1 and cfg_done=0. A following start clears cfg_error.
- s_valid deasserted for 3 cycles between words 2 and 3: no cfg_shift during the gap; cfg_bit sequence is unchanged.
- abort during the 2nd word's SHIFT, and separately rst_n low mid-load: IDLE on the next edge (abort) or immediately (reset); flags 0. A restart then completes a clean 4-word load.
